// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-subset instruction descriptors and writes them to consecutive
// instruction-memory words. Optional running XOR checksum when INSTR_CHECKSUM_EN is defined.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_accepted;
    logic [ADDR_W:0]   r_written;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [31:0]       r_out_word;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_fire;
    logic              w_accept;
    logic              w_load;
    logic              w_start_ok;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_word  = 32'd0;
        w_legal = 1'b1;
        case (in_op)
            4'd0:    w_word = {6'd35, in_rs, in_rt, in_imm};
            4'd1:    w_word = {6'd43, in_rs, in_rt, in_imm};
            4'd2:    w_word = {6'd5, in_rs, in_rt, in_imm};
            4'd3:    w_word = {6'd14, in_rs, in_rt, in_imm};
            4'd4:    w_word = {6'd2, in_target};
            4'd5:    w_word = {6'd3, in_target};
            4'd6:    w_word = {6'd0, in_rs, 15'd0, 6'd8};
            4'd7:    w_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd32};
            4'd8:    w_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd34};
            4'd9:    w_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd42};
            default: w_legal = 1'b0;
        endcase
    end

    // The output register may reload in the same cycle its word is taken by the memory.
    assign w_fire     = r_out_valid & imem_ready;
    assign in_ready   = (r_state == S_LOAD) & (r_accepted < r_count) & (~r_out_valid | w_fire);
    assign w_accept   = in_valid & in_ready;
    assign w_load     = w_accept & w_legal;
    assign busy       = (r_state == S_LOAD) | r_out_valid;
    assign w_start_ok = start & ~busy;
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign imem_we    = r_out_valid;
    assign imem_addr  = r_out_addr;
    assign imem_wdata = r_out_word;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_accept && !w_legal) begin
                    w_next_state = S_ERR;
                end else if (w_fire && ((r_written + CNT_ONE) == r_count)) begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                if (w_start_ok) begin
                    w_next_state = (count == '0) ? S_DONE : S_LOAD;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_count     <= '0;
            r_accepted  <= '0;
            r_written   <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_word  <= '0;
        end else if (w_start_ok) begin
            r_base     <= base_addr;
            r_count    <= count;
            r_accepted <= '0;
            r_written  <= '0;
        end else begin
            if (w_load) begin
                r_accepted  <= r_accepted + CNT_ONE;
                r_out_valid <= 1'b1;
                r_out_addr  <= r_base + r_accepted[ADDR_W-1:0];
                r_out_word  <= w_word;
            end else if (w_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_fire) begin
                r_written <= r_written + CNT_ONE;
            end
        end
    end

`ifdef INSTR_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_fire) begin
            r_checksum <= r_checksum ^ r_out_word;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized sessions
// scored against an arithmetic encoding model and an expected-write queue.
module tb_instr_encoder;

    localparam int ADDR_W = 10;

    typedef struct {
        int op;
        int rs;
        int rt;
        int rd;
        int imm;
        int tgt;
    } desc_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       checksum;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          cur_base = 0;
    int          idx = 0;
    int          n_writes = 0;
    logic [31:0] model_sum = 32'd0;
    bit          rand_ready = 1'b0;
    wr_t         exp_q[$];
    int          wr_cycles[$];

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .count      (count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference encoding built from the opcode/funct tables with plain arithmetic.
    function automatic logic [31:0] model_enc(input desc_t d);
        int     opcode[10] = '{35, 43, 5, 14, 2, 3, 0, 0, 0, 0};
        int     funct[10]  = '{0, 0, 0, 0, 0, 0, 8, 32, 34, 42};
        longint p26 = 64'd67108864;
        longint p21 = 64'd2097152;
        longint p16 = 64'd65536;
        longint p11 = 64'd2048;
        longint w;
        if (d.op <= 3)      w = opcode[d.op] * p26 + d.rs * p21 + d.rt * p16 + d.imm;
        else if (d.op <= 5) w = opcode[d.op] * p26 + d.tgt;
        else if (d.op == 6) w = d.rs * p21 + funct[d.op];
        else                w = d.rs * p21 + d.rt * p16 + d.rd * p11 + funct[d.op];
        return 32'(w);
    endfunction

    function automatic logic [31:0] exp_checksum();
`ifdef INSTR_CHECKSUM_EN
        return model_sum;
`else
        return 32'd0;
`endif
    endfunction

    function automatic desc_t rand_desc(input int op);
        desc_t d;
        d.op  = op;
        d.rs  = int'($urandom_range(0, 31));
        d.rt  = int'($urandom_range(0, 31));
        d.rd  = int'($urandom_range(0, 31));
        d.imm = int'($urandom_range(0, 65535));
        d.tgt = int'($urandom_range(0, (1 << 26) - 1));
        return d;
    endfunction

    function automatic desc_t mk_desc(input int op, input int rs, input int rt, input int rd,
                                      input int imm, input int tgt);
        desc_t d;
        d.op = op; d.rs = rs; d.rt = rt; d.rd = rd; d.imm = imm; d.tgt = tgt;
        return d;
    endfunction

    // Completed writes are compared in order against what the model expects.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && imem_we && imem_ready) begin
            n_writes++;
            wr_cycles.push_back(cyc);
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.word);
                model_sum ^= e.word;
            end
        end
    end

    task automatic drive_desc(input desc_t d);
        in_valid  = 1'b1;
        in_op     = 4'(d.op);
        in_rs     = 5'(d.rs);
        in_rt     = 5'(d.rt);
        in_rd     = 5'(d.rd);
        in_imm    = 16'(d.imm);
        in_target = 26'(d.tgt);
    endtask

    task automatic model_accept(input desc_t d);
        wr_t e;
        if (d.op < 10) begin
            e.addr = ADDR_W'((cur_base + idx) % (1 << ADDR_W));
            e.word = model_enc(d);
            exp_q.push_back(e);
            idx++;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the descriptor.
    task automatic send(input desc_t d);
        bit acc = 1'b0;
        drive_desc(d);
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                model_accept(d);
            end
            @(posedge clk);
            #1;
            if (rand_ready) imem_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        check("accept_in_time", 32'(acc), 32'd1);
    endtask

    task automatic do_start(input int base, input int cnt);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        count     = (ADDR_W + 1)'(cnt);
        cur_base  = base;
        idx       = 0;
        n_writes  = 0;
        model_sum = 32'd0;
        exp_q.delete();
        wr_cycles.delete();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns on the falling edge where done is first seen.
    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (rand_ready) imem_ready = ($urandom_range(0, 3) != 0);
            end
        end
        check("done_in_time", 32'(seen), 32'd1);
    endtask

    task automatic check_session_end(input string tag, input int cnt);
        check({tag, "_writes"}, 32'(n_writes), 32'(cnt));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_checksum"}, checksum, exp_checksum());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_checksum"}, checksum, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        desc_t d1;
        desc_t d2;
        int    cnt;
        int    wr_before;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
        in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_target = '0; imem_ready = 1'b1;

        // Reset state
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic session: ADD, LW, J back to back
        do_start(32'h010, 3);
        check("start_busy", 32'(busy), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd1);
        send(mk_desc(7, 1, 2, 3, 0, 0));
        check("basic0_we", 32'(imem_we), 32'd1);
        check("basic0_addr", 32'(imem_addr), 32'h010);
        check("basic0_data", imem_wdata, 32'h00221820);
        send(mk_desc(0, 29, 8, 0, 4, 0));
        check("basic1_addr", 32'(imem_addr), 32'h011);
        check("basic1_data", imem_wdata, 32'h8FA80004);
        send(mk_desc(4, 0, 0, 0, 0, 32'h40));
        check("basic2_addr", 32'(imem_addr), 32'h012);
        check("basic2_data", imem_wdata, 32'h08000040);
        @(negedge clk);
        check("basic_done_during_last", 32'(done), 32'd0);
        @(negedge clk);
        check("basic_done_after_last", 32'(done), 32'd1);
        check("basic_write_count", 32'(wr_cycles.size()), 32'd3);
        if (wr_cycles.size() == 3) begin
            check("basic_consecutive_1", 32'(wr_cycles[1] - wr_cycles[0]), 32'd1);
            check("basic_consecutive_2", 32'(wr_cycles[2] - wr_cycles[1]), 32'd1);
            check("basic_done_latency", 32'(cyc - wr_cycles[2]), 32'd1);
        end
        check_session_end("basic", 3);

        // Backpressure: pending word held, second descriptor waits, no bubble on release
        imem_ready = 1'b0;
        do_start(32'h100, 2);
        d1 = rand_desc(1);
        send(d1);
        d2 = rand_desc(8);
        drive_desc(d2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_we", 32'(imem_we), 32'd1);
            check("bp_addr", 32'(imem_addr), 32'h100);
            check("bp_data", imem_wdata, model_enc(d1));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        check("bp_no_write", 32'(n_writes), 32'd0);
        @(posedge clk);
        #1;
        imem_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        if (in_ready) model_accept(d2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_reload_we", 32'(imem_we), 32'd1);
        check("bp_reload_addr", 32'(imem_addr), 32'h101);
        check("bp_reload_data", imem_wdata, model_enc(d2));
        wait_done(20);
        if (wr_cycles.size() == 2) begin
            check("bp_no_bubble", 32'(wr_cycles[1] - wr_cycles[0]), 32'd1);
        end
        check_session_end("bp", 2);

        // Illegal op: ADD is written, op 12 aborts the session
        do_start(32'h200, 4);
        send(rand_desc(7));
        send(rand_desc(12));
        check("ill_err", 32'(err), 32'd1);
        check("ill_busy", 32'(busy), 32'd0);
        check("ill_in_ready", 32'(in_ready), 32'd0);
        check("ill_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ill_no_we", 32'(imem_we), 32'd0);
        end
        check("ill_writes", 32'(n_writes), 32'd1);
        check("ill_pending", 32'(exp_q.size()), 32'd0);
        do_start(32'h000, 1);
        check("ill_restart_err", 32'(err), 32'd0);
        check("ill_restart_busy", 32'(busy), 32'd1);
        send(rand_desc(6));
        wait_done(20);
        check_session_end("ill_restart", 1);

        // Address wrap at the top of the word space
        do_start(32'h3FF, 2);
        send(rand_desc(3));
        check("wrap_addr_top", 32'(imem_addr), 32'h3FF);
        send(rand_desc(5));
        check("wrap_addr_zero", 32'(imem_addr), 32'h000);
        wait_done(20);
        check_session_end("wrap", 2);

        // Empty session
        do_start(32'h055, 0);
        @(negedge clk);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_in_ready", 32'(in_ready), 32'd0);
        check("empty_we", 32'(imem_we), 32'd0);

        // Randomized sessions with random memory backpressure
        rand_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            cnt = int'($urandom_range(1, 6));
            do_start(int'($urandom_range(0, (1 << ADDR_W) - 1)), cnt);
            check("rand_start_busy", 32'(busy), 32'd1);
            for (int k = 0; k < cnt; k++) send(rand_desc(int'($urandom_range(0, 9))));
            wait_done(300);
            check_session_end("rand", cnt);
        end
        rand_ready = 1'b0;

        // Reset mid-session drops the pending write
        imem_ready = 1'b0;
        do_start(32'h300, 3);
        send(rand_desc(0));
        check("mid_pending_we", 32'(imem_we), 32'd1);
        wr_before = n_writes;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_we", 32'(imem_we), 32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
        end
        check("midrst_no_write", 32'(n_writes - wr_before), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
